// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: arbitrates between a control-segment requester and a
// data-segment requester for a single TCP transmitter. The winner's header
// is latched and handed to the transmitter with start pulses, and the arbiter
// waits for the transmitter's completion pulse or a timeout.
//
// Optional build macro: TX_ARB_STARVE_GUARD_EN
//   Defined   - a starvation counter lets data win once STARVE_LIMIT
//               consecutive control grants happened while data was pending.
//   Undefined - strict control priority; no starvation counter exists.
module tcp_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [3:0]  STARVE_LIMIT   = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_req_i,
  input  logic [5:0]  ctrl_flags_i,
  input  logic [31:0] ctrl_seq_i,
  input  logic [31:0] ctrl_ack_i,
  input  logic [3:0]  ctrl_head_len_i,
  input  logic        data_req_i,
  input  logic [31:0] data_seq_i,
  input  logic [31:0] data_ack_i,
  input  logic [15:0] data_len_i,
  input  logic        tcp_write_op_end_i,
  output logic        ctrl_gnt_o,
  output logic        data_gnt_o,
  output logic        tcp_start_o,
  output logic        wdat_start_o,
  output logic [5:0]  tcp_flags_o,
  output logic [31:0] tcp_seq_num_o,
  output logic [31:0] tcp_ack_num_o,
  output logic [3:0]  tcp_head_len_o,
  output logic [15:0] tcp_data_len_o,
  output logic        data_done_o,
  output logic        timeout_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    START    = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        winner_data_r;
  logic        winner_data_s;
  logic [15:0] tmo_cnt_r;
  logic [15:0] tmo_cnt_s;
  logic        data_wins_s;
  logic        ctrl_gnt_s;
  logic        data_gnt_s;
  logic        tcp_start_s;
  logic        wdat_start_s;
  logic        data_done_s;
  logic        timeout_s;
  logic        cap_hdr_s;

`ifdef TX_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_r;

  // Data wins when it is the only requester or when control has starved it.
  always_comb begin
    data_wins_s = data_req_i && (!ctrl_req_i || (starve_cnt_r >= STARVE_LIMIT));
  end

  // Count consecutive control grants issued while data is kept waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (!data_req_i) begin
      starve_cnt_r <= 4'd0;
    end else if (data_gnt_s) begin
      starve_cnt_r <= 4'd0;
    end else if (ctrl_gnt_s && (starve_cnt_r != 4'd15)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  // Strict priority: data wins only when control is not requesting.
  always_comb begin
    data_wins_s = data_req_i && !ctrl_req_i;
  end
`endif

  // Next-state and next-pulse decode; requests are only looked at in IDLE.
  always_comb begin
    next_state_s  = state_r;
    winner_data_s = winner_data_r;
    tmo_cnt_s     = tmo_cnt_r;
    ctrl_gnt_s    = 1'b0;
    data_gnt_s    = 1'b0;
    tcp_start_s   = 1'b0;
    wdat_start_s  = 1'b0;
    data_done_s   = 1'b0;
    timeout_s     = 1'b0;
    cap_hdr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (ctrl_req_i || data_req_i) begin
          next_state_s  = GRANT;
          winner_data_s = data_wins_s;
          ctrl_gnt_s    = !data_wins_s;
          data_gnt_s    = data_wins_s;
        end else begin
          next_state_s  = IDLE;
        end
      end
      GRANT: begin
        // Requester still holds its fields during the grant cycle.
        next_state_s = START;
        cap_hdr_s    = 1'b1;
        tcp_start_s  = 1'b1;
        wdat_start_s = winner_data_r;
      end
      START: begin
        next_state_s = WAIT_END;
        tmo_cnt_s    = 16'd0;
      end
      WAIT_END: begin
        if (tcp_write_op_end_i) begin
          next_state_s = IDLE;
          data_done_s  = winner_data_r;
        end else if (tmo_cnt_r >= (TIMEOUT_CYCLES - 16'd1)) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          tmo_cnt_s    = tmo_cnt_r + 16'd1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state, winner type and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      winner_data_r <= 1'b0;
      tmo_cnt_r     <= 16'd0;
    end else begin
      state_r       <= next_state_s;
      winner_data_r <= winner_data_s;
      tmo_cnt_r     <= tmo_cnt_s;
    end
  end

  // Registered pulse and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_gnt_o   <= 1'b0;
      data_gnt_o   <= 1'b0;
      tcp_start_o  <= 1'b0;
      wdat_start_o <= 1'b0;
      data_done_o  <= 1'b0;
      timeout_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      ctrl_gnt_o   <= ctrl_gnt_s;
      data_gnt_o   <= data_gnt_s;
      tcp_start_o  <= tcp_start_s;
      wdat_start_o <= wdat_start_s;
      data_done_o  <= data_done_s;
      timeout_o    <= timeout_s;
      busy_o       <= (next_state_s != IDLE);
    end
  end

  // Header latch: loaded once per segment, stable through WAIT_END.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcp_flags_o    <= 6'h00;
      tcp_seq_num_o  <= 32'd0;
      tcp_ack_num_o  <= 32'd0;
      tcp_head_len_o <= 4'd5;
      tcp_data_len_o <= 16'd0;
    end else if (cap_hdr_s && winner_data_r) begin
      tcp_flags_o    <= 6'h18;
      tcp_seq_num_o  <= data_seq_i;
      tcp_ack_num_o  <= data_ack_i;
      tcp_head_len_o <= 4'd5;
      tcp_data_len_o <= data_len_i;
    end else if (cap_hdr_s) begin
      tcp_flags_o    <= ctrl_flags_i;
      tcp_seq_num_o  <= ctrl_seq_i;
      tcp_ack_num_o  <= ctrl_ack_i;
      tcp_head_len_o <= ctrl_head_len_i;
      tcp_data_len_o <= 16'd0;
    end else begin
      tcp_flags_o    <= tcp_flags_o;
      tcp_seq_num_o  <= tcp_seq_num_o;
      tcp_ack_num_o  <= tcp_ack_num_o;
      tcp_head_len_o <= tcp_head_len_o;
      tcp_data_len_o <= tcp_data_len_o;
    end
  end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed testbench for tcp_tx_arbiter (default parameters).
module tb_tcp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_req_i = 1'b0;
  logic [5:0]  ctrl_flags_i = 6'h00;
  logic [31:0] ctrl_seq_i = 32'd0;
  logic [31:0] ctrl_ack_i = 32'd0;
  logic [3:0]  ctrl_head_len_i = 4'd5;
  logic        data_req_i = 1'b0;
  logic [31:0] data_seq_i = 32'd0;
  logic [31:0] data_ack_i = 32'd0;
  logic [15:0] data_len_i = 16'd0;
  logic        tcp_write_op_end_i = 1'b0;
  logic        ctrl_gnt_o, data_gnt_o, tcp_start_o, wdat_start_o;
  logic [5:0]  tcp_flags_o;
  logic [31:0] tcp_seq_num_o, tcp_ack_num_o;
  logic [3:0]  tcp_head_len_o;
  logic [15:0] tcp_data_len_o;
  logic        data_done_o, timeout_o, busy_o;

  int checks = 0;
  int passed = 0;

  tcp_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .ctrl_req_i(ctrl_req_i), .ctrl_flags_i(ctrl_flags_i), .ctrl_seq_i(ctrl_seq_i),
    .ctrl_ack_i(ctrl_ack_i), .ctrl_head_len_i(ctrl_head_len_i),
    .data_req_i(data_req_i), .data_seq_i(data_seq_i), .data_ack_i(data_ack_i),
    .data_len_i(data_len_i), .tcp_write_op_end_i(tcp_write_op_end_i),
    .ctrl_gnt_o(ctrl_gnt_o), .data_gnt_o(data_gnt_o), .tcp_start_o(tcp_start_o),
    .wdat_start_o(wdat_start_o), .tcp_flags_o(tcp_flags_o), .tcp_seq_num_o(tcp_seq_num_o),
    .tcp_ack_num_o(tcp_ack_num_o), .tcp_head_len_o(tcp_head_len_o),
    .tcp_data_len_o(tcp_data_len_o), .data_done_o(data_done_o), .timeout_o(timeout_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_end();
    tcp_write_op_end_i = 1'b1;
    step();
    tcp_write_op_end_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else passed++;
    checks++; if ({ctrl_gnt_o, data_gnt_o, tcp_start_o, wdat_start_o, data_done_o, timeout_o} !== 6'b0)
      $display("FAIL reset_pulses got %b exp 000000",
               {ctrl_gnt_o, data_gnt_o, tcp_start_o, wdat_start_o, data_done_o, timeout_o});
    else passed++;
    checks++; if (tcp_flags_o !== 6'h00) $display("FAIL reset_flags got %h exp 00", tcp_flags_o); else passed++;
    checks++; if (tcp_seq_num_o !== 32'd0 || tcp_ack_num_o !== 32'd0)
      $display("FAIL reset_seq_ack got %h/%h exp 0/0", tcp_seq_num_o, tcp_ack_num_o); else passed++;
    checks++; if (tcp_head_len_o !== 4'd5) $display("FAIL reset_head_len got %0d exp 5", tcp_head_len_o); else passed++;
    checks++; if (tcp_data_len_o !== 16'd0) $display("FAIL reset_data_len got %0d exp 0", tcp_data_len_o); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_ctrl_only();
    ctrl_flags_i = 6'h12; ctrl_seq_i = 32'd0; ctrl_ack_i = 32'h1001; ctrl_head_len_i = 4'd6;
    ctrl_req_i = 1'b1;
    step();
    checks++; if (ctrl_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || tcp_start_o !== 1'b0)
      $display("FAIL ctrl_gnt got c%b d%b s%b exp c1 d0 s0", ctrl_gnt_o, data_gnt_o, tcp_start_o); else passed++;
    checks++; if (busy_o !== 1'b1) $display("FAIL ctrl_busy got %b exp 1", busy_o); else passed++;
    ctrl_req_i = 1'b0;
    step();
    checks++; if (tcp_start_o !== 1'b1 || wdat_start_o !== 1'b0 || ctrl_gnt_o !== 1'b0)
      $display("FAIL ctrl_start got s%b w%b g%b exp s1 w0 g0", tcp_start_o, wdat_start_o, ctrl_gnt_o); else passed++;
    checks++; if (tcp_flags_o !== 6'h12 || tcp_ack_num_o !== 32'h1001 || tcp_seq_num_o !== 32'd0)
      $display("FAIL ctrl_hdr got %h/%h/%h exp 12/0/1001", tcp_flags_o, tcp_seq_num_o, tcp_ack_num_o); else passed++;
    checks++; if (tcp_data_len_o !== 16'd0 || tcp_head_len_o !== 4'd6)
      $display("FAIL ctrl_len got %0d/%0d exp 0/6", tcp_data_len_o, tcp_head_len_o); else passed++;
    step();
    checks++; if (tcp_start_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL ctrl_wait got s%b b%b exp s0 b1", tcp_start_o, busy_o); else passed++;
    pulse_end();
    checks++; if (busy_o !== 1'b0 || data_done_o !== 1'b0)
      $display("FAIL ctrl_end got b%b dd%b exp b0 dd0", busy_o, data_done_o); else passed++;
    step();
  endtask

  task automatic test_data_only();
    data_seq_i = 32'h1; data_ack_i = 32'h2000; data_len_i = 16'd1450;
    data_req_i = 1'b1;
    step();
    checks++; if (data_gnt_o !== 1'b1 || ctrl_gnt_o !== 1'b0)
      $display("FAIL data_gnt got d%b c%b exp d1 c0", data_gnt_o, ctrl_gnt_o); else passed++;
    data_req_i = 1'b0;
    step();
    checks++; if (tcp_start_o !== 1'b1 || wdat_start_o !== 1'b1)
      $display("FAIL data_start got s%b w%b exp s1 w1", tcp_start_o, wdat_start_o); else passed++;
    checks++; if (tcp_flags_o !== 6'h18 || tcp_head_len_o !== 4'd5 || tcp_data_len_o !== 16'd1450)
      $display("FAIL data_hdr got %h/%0d/%0d exp 18/5/1450", tcp_flags_o, tcp_head_len_o, tcp_data_len_o); else passed++;
    checks++; if (tcp_seq_num_o !== 32'h1 || tcp_ack_num_o !== 32'h2000)
      $display("FAIL data_seq got %h/%h exp 1/2000", tcp_seq_num_o, tcp_ack_num_o); else passed++;
    step();
    checks++; if (wdat_start_o !== 1'b0) $display("FAIL data_wdat_once got %b exp 0", wdat_start_o); else passed++;
    pulse_end();
    checks++; if (data_done_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL data_done got dd%b b%b exp dd1 b0", data_done_o, busy_o); else passed++;
    step();
    checks++; if (data_done_o !== 1'b0) $display("FAIL data_done_once got %b exp 0", data_done_o); else passed++;
  endtask

  task automatic test_end_ignored();
    pulse_end();
    checks++; if (busy_o !== 1'b0 || data_done_o !== 1'b0)
      $display("FAIL idle_end got b%b dd%b exp b0 dd0", busy_o, data_done_o); else passed++;
    data_req_i = 1'b1;
    step();                        // now GRANT
    data_req_i = 1'b0;
    tcp_write_op_end_i = 1'b1;
    step();                        // end seen in GRANT, now START
    step();                        // end seen in START, now WAIT_END
    tcp_write_op_end_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || data_done_o !== 1'b0)
      $display("FAIL early_end got b%b dd%b exp b1 dd0", busy_o, data_done_o); else passed++;
    pulse_end();
    checks++; if (data_done_o !== 1'b1) $display("FAIL late_end got %b exp 1", data_done_o); else passed++;
    step();
  endtask

  task automatic test_priority();
    ctrl_req_i = 1'b1; data_req_i = 1'b1;
    step();
    checks++; if (ctrl_gnt_o !== 1'b1 || data_gnt_o !== 1'b0)
      $display("FAIL prio_first got c%b d%b exp c1 d0", ctrl_gnt_o, data_gnt_o); else passed++;
    ctrl_req_i = 1'b0;
    step();
    step();
    ctrl_req_i = 1'b1;             // arrives while busy: must be ignored
    step();
    checks++; if (ctrl_gnt_o !== 1'b0 || data_gnt_o !== 1'b0)
      $display("FAIL busy_ignore got c%b d%b exp c0 d0", ctrl_gnt_o, data_gnt_o); else passed++;
    ctrl_req_i = 1'b0;
    pulse_end();
    checks++; if (busy_o !== 1'b0 || data_gnt_o !== 1'b0)
      $display("FAIL return_no_gnt got b%b d%b exp b0 d0", busy_o, data_gnt_o); else passed++;
    step();
    checks++; if (data_gnt_o !== 1'b1 || ctrl_gnt_o !== 1'b0)
      $display("FAIL prio_second got d%b c%b exp d1 c0", data_gnt_o, ctrl_gnt_o); else passed++;
    data_req_i = 1'b0;
    step();
    step();
    pulse_end();
    step();
  endtask

  task automatic test_starve();
    logic exp_data;
    ctrl_req_i = 1'b1; data_req_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef TX_ARB_STARVE_GUARD_EN
      exp_data = (i == 4);
`else
      exp_data = 1'b0;
`endif
      checks++; if (data_gnt_o !== exp_data || ctrl_gnt_o !== !exp_data)
        $display("FAIL starve_seg%0d got d%b c%b exp d%b c%b", i, data_gnt_o, ctrl_gnt_o, exp_data, !exp_data);
      else passed++;
      step();
      step();
      pulse_end();
    end
    ctrl_req_i = 1'b0; data_req_i = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    bit  done_seen;
    data_req_i = 1'b1;
    step();
    data_req_i = 1'b0;
    step();                        // START cycle
    n = 0; seen = 1'b0; done_seen = 1'b0;
    while (!seen && n < 50100) begin
      step();
      n++;
      if (timeout_o === 1'b1) seen = 1'b1;
      if (data_done_o === 1'b1) done_seen = 1'b1;
    end
    checks++; if (!seen) $display("FAIL timeout_seen got none in %0d cycles exp pulse", n); else passed++;
    checks++; if (n < 49990 || n > 50010) $display("FAIL timeout_delay got %0d exp ~50001", n); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL timeout_idle got %b exp 0", busy_o); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (timeout_o === 1'b1) seen = 1'b1;
      if (data_done_o === 1'b1) done_seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL timeout_once got repeat exp single pulse"); else passed++;
    checks++; if (done_seen) $display("FAIL timeout_no_done got 1 exp 0"); else passed++;
  endtask

  task automatic test_reset_midsegment();
    ctrl_flags_i = 6'h11; ctrl_seq_i = 32'hABCD; ctrl_ack_i = 32'h55; ctrl_head_len_i = 4'd7;
    ctrl_req_i = 1'b1;
    step();
    step();
    step();                        // WAIT_END
    checks++; if (busy_o !== 1'b1 || tcp_flags_o !== 6'h11)
      $display("FAIL mid_busy got b%b f%h exp b1 f11", busy_o, tcp_flags_o); else passed++;
    rst = 1'b1;
    step();
    checks++; if (busy_o !== 1'b0 || ctrl_gnt_o !== 1'b0 || tcp_start_o !== 1'b0)
      $display("FAIL mid_rst got b%b g%b s%b exp 000", busy_o, ctrl_gnt_o, tcp_start_o); else passed++;
    checks++; if (tcp_flags_o !== 6'h00 || tcp_seq_num_o !== 32'd0 || tcp_head_len_o !== 4'd5)
      $display("FAIL mid_rst_hdr got %h/%h/%0d exp 00/0/5", tcp_flags_o, tcp_seq_num_o, tcp_head_len_o); else passed++;
    rst = 1'b0;
    step();
    checks++; if (ctrl_gnt_o !== 1'b1) $display("FAIL regrant got %b exp 1", ctrl_gnt_o); else passed++;
    ctrl_req_i = 1'b0;
    step();
    step();
    pulse_end();
    step();
  endtask

  initial begin
    test_reset();
    test_ctrl_only();
    test_data_only();
    test_end_ignored();
    test_priority();
    test_starve();
    test_reset_midsegment();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
